score_controller: RTL
=====================

# score_controller

Game-score sequencer for Dino Run. It runs the IDLE/RUN/DEAD game state machine, counts a 4-digit BCD score from game-frame ticks, and keeps a high score. It drives the `alive` and `score3..score0` inputs of the seven-segment display driver, and feeds a difficulty level to the obstacle generator.

## Interface
Parameters:
- `TICKS_PER_POINT`, default 10: game ticks per score point (≥1).
- `SPEED_STEPS`, default 3: maximum value of `speed_level`.

Ports:
- `clk`  in  1  system clock; all logic on rising edge.
- `rst_n`  in  1  reset, asynchronous, active-low.
- `game_tick`  in  1  one-cycle pulse per game frame.
- `start`  in  1  one-cycle pulse; start or restart a run.
- `collision`  in  1  level; dino has hit an obstacle.
- `show_high`  in  1  level; in DEAD, display high score instead of last score.
- `alive`  out  1  1 in IDLE/RUN, 0 in DEAD; drives display blink.
- `score3`, `score2`, `score1`, `score0`  out  4 each  displayed BCD digits, thousands to units.
- `new_high`  out  1  in DEAD, last run set a new high score.
- `speed_level`  out  2  difficulty, 0..SPEED_STEPS.

## Operation
- States:
  - IDLE (reset state): score held at 0000; `collision` and `game_tick` ignored.
  - `start` in IDLE → RUN.
  - RUN: count `game_tick` in prescaler `0..TICKS_PER_POINT-1`. When the prescaler wraps (tick while at max), the score increments by 1 in BCD with per-digit 9→0 carry.
  - Score saturates at 9999. Further increments are dropped, and the prescaler keeps running.
  - `collision`=1 in RUN → DEAD. In the same edge:
    - if score > high (16-bit compare of concatenated BCD digits, which is order-preserving), high ← score and `new_high` ← 1;
    - otherwise `new_high` ← 0.
  - Collision and score-increment on the same cycle: collision wins. The increment is discarded, and high-score compare uses the pre-increment score.
  - `start` during RUN is ignored.
  - DEAD: score frozen. `start` → RUN, with score, prescaler and `speed_level` cleared to 0 and `new_high` cleared.
  - `start` and `collision` together in DEAD: start wins.
- `speed_level`:
  - increments by 1 each time the hundreds digit carries (score passes a multiple of 100), saturating at SPEED_STEPS;
  - holds in DEAD; cleared on start.
- Display mux: digits show high score when state==DEAD and `show_high`=1; otherwise they show the current score.
- High score survives restarts; only `rst_n` clears it.

## Timing
- All outputs are registered. Reset values:
  - `alive`=1
  - `score3..0`=0
  - `new_high`=0
  - `speed_level`=0
  - internal: high score 0000, prescaler 0, state IDLE.
- `rst_n` low mid-run forces the reset values asynchronously. High score is lost.
- Score digits reflect an increment 1 cycle after the wrapping `game_tick` edge.
- `alive` falls 1 cycle after `collision` is sampled in RUN. `new_high` is valid on the same cycle.
- `show_high` change reaches the digits 1 cycle later.
- `start`→RUN: `alive`=1 and digits 0000 on the next cycle. The first point needs TICKS_PER_POINT further ticks.
- A `game_tick` coincident with `start` is not counted.

## Structure
- Package `dino_pkg`:
  - state enum `game_state_t` {IDLE, RUN, DEAD};
  - `bcd_digit_t` (4-bit);
  - `SCORE_MAX` = 16'h9999.
- Sub-module `bcd_counter4`:
  - inputs: 4-digit BCD register, synchronous clear, increment enable;
  - outputs: saturation at 9999, and a one-cycle `hundreds_carry` pulse for the speed logic.
- Top holds the FSM, prescaler, high-score register, compare, and output mux.

## Test plan
- Reset, then `start`, then 30 ticks with TICKS_PER_POINT=10 → digits 0003, `alive`=1, `speed_level`=0.
- Preload score 0099 via ticks, 10 more ticks → 0100 and `speed_level`=1. Continue past 0400 → `speed_level` stays 3.
- Run to 0250, then `collision` → next cycle `alive`=0, `new_high`=1. With `show_high`=1 the digits show 0250.
- Restart and die at 0120 → `new_high`=0. `show_high`=1 shows 0250, `show_high`=0 shows 0120.
- Collision on the same cycle as the 10th tick at score 0041 → frozen at 0041. Also: `start`+`collision` together in DEAD → RUN, digits 0000.
- Run to 9999, 50 more ticks → digits stay 9999. Assert `rst_n`=0 mid-run → all outputs at reset values immediately, and after release the high score is 0000.

Source files
------------

// File: rtl/dino_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Package     : dino_pkg                                               |
// | Description : Shared types and constants for the Dino Run score      |
// |               sequencer.                                             |
// | Revision    : 1.0 - initial release                                  |
// +----------------------------------------------------------------------+
package dino_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DEAD = 2'd2
    } game_state_t;

    typedef logic [3:0] bcd_digit_t;

    localparam logic [15:0] SCORE_MAX = 16'h9999;

endpackage : dino_pkg
`default_nettype wire

// File: rtl/bcd_counter4.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module      : bcd_counter4                                           |
// | Description : Four-digit BCD score register with synchronous clear,  |
// |               saturation at 9999 and a hundreds-carry strobe.        |
// | Revision    : 1.0 - initial release                                  |
// +----------------------------------------------------------------------+
module bcd_counter4
    import dino_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic        i_clr,
    input  logic        i_inc,
    output logic [15:0] o_score,
    output logic [15:0] o_score_next,
    output logic        o_sat,
    output logic        o_hundreds_carry
);

    logic [15:0] r_score;
    logic [15:0] w_sum;
    logic        w_carry;
    logic        w_step;

    // Ripple a +1 through the four digits, each digit wrapping 9 -> 0.
    always_comb begin
        w_sum   = r_score;
        w_carry = 1'b1;
        for (int i = 0; i < 4; i++) begin
            if (w_carry) begin
                if (r_score[4*i +: 4] == 4'd9) begin
                    w_sum[4*i +: 4] = 4'd0;
                end else begin
                    w_sum[4*i +: 4] = r_score[4*i +: 4] + 4'd1;
                    w_carry         = 1'b0;
                end
            end
        end
    end

    // Next-value select: clear dominates, increments are dropped at 9999.
    always_comb begin
        o_sat            = (r_score == SCORE_MAX);
        w_step           = i_inc && !o_sat;
        o_score_next     = i_clr ? 16'h0000 : (w_step ? w_sum : r_score);
        o_hundreds_carry = !i_clr && w_step && (r_score[7:0] == 8'h99);
    end

    // Score register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_score <= 16'h0000;
        end else begin
            r_score <= o_score_next;
        end
    end

    assign o_score = r_score;

endmodule : bcd_counter4
`default_nettype wire

// File: rtl/score_controller.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module      : score_controller                                       |
// | Description : Dino Run game FSM, tick prescaler, BCD score, high     |
// |               score tracking, difficulty level and display mux.      |
// | Revision    : 1.0 - initial release                                  |
// +----------------------------------------------------------------------+
module score_controller
    import dino_pkg::*;
#(
    parameter int TICKS_PER_POINT = 10,
    parameter int SPEED_STEPS     = 3
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       game_tick,
    input  logic       start,
    input  logic       collision,
    input  logic       show_high,
    output logic       alive,
    output logic [3:0] score3,
    output logic [3:0] score2,
    output logic [3:0] score1,
    output logic [3:0] score0,
    output logic       new_high,
    output logic [1:0] speed_level
);

    localparam int                    c_PRESC_W   = (TICKS_PER_POINT > 1) ? $clog2(TICKS_PER_POINT) : 1;
    localparam logic [c_PRESC_W-1:0]  c_PRESC_MAX = c_PRESC_W'(TICKS_PER_POINT - 1);
    localparam logic [c_PRESC_W-1:0]  c_PRESC_ONE = c_PRESC_W'(1);
    localparam logic [1:0]            c_SPEED_MAX = 2'(SPEED_STEPS);

    game_state_t            r_state;
    game_state_t            w_state_next;
    logic [c_PRESC_W-1:0]   r_presc;
    logic [15:0]            r_high;
    logic [15:0]            w_high_next;
    logic                   r_new_high;
    logic [1:0]             r_speed;
    logic                   r_alive;
    logic [15:0]            r_disp;

    logic [15:0]            w_score;
    logic [15:0]            w_score_next;
    logic                   w_sat;
    logic                   w_hcarry;
    logic                   w_in_run;
    logic                   w_wrap;
    logic                   w_collide;
    logic                   w_restart;
    logic                   w_inc;
    logic                   w_beats_high;

    // Event decode. Collision in RUN suppresses a coincident increment.
    always_comb begin
        w_in_run     = (r_state == RUN);
        w_wrap       = w_in_run && game_tick && (r_presc == c_PRESC_MAX);
        w_collide    = w_in_run && collision;
        w_restart    = start && (r_state != RUN);
        w_inc        = w_wrap && !collision && !w_sat;
        w_beats_high = (w_score > r_high);
        w_high_next  = (w_collide && w_beats_high) ? w_score : r_high;
    end

    bcd_counter4 u_bcd_counter4 (
        .clk              (clk),
        .rst_n            (rst_n),
        .i_clr            (w_restart),
        .i_inc            (w_inc),
        .o_score          (w_score),
        .o_score_next     (w_score_next),
        .o_sat            (w_sat),
        .o_hundreds_carry (w_hcarry)
    );

    // Game state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next-state logic; in DEAD a start beats a simultaneous collision.
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            IDLE:    if (start)     w_state_next = RUN;
            RUN:     if (collision) w_state_next = DEAD;
            DEAD:    if (start)     w_state_next = RUN;
            default:                w_state_next = IDLE;
        endcase
    end

    // Tick prescaler: keeps running even once the score has saturated.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_presc <= '0;
        end else if (w_restart) begin
            r_presc <= '0;
        end else if (w_in_run && game_tick) begin
            r_presc <= (r_presc == c_PRESC_MAX) ? '0 : (r_presc + c_PRESC_ONE);
        end
    end

    // High score capture and new-high flag on death; flag cleared on restart.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_high     <= 16'h0000;
            r_new_high <= 1'b0;
        end else begin
            r_high <= w_high_next;
            if (w_restart) begin
                r_new_high <= 1'b0;
            end else if (w_collide) begin
                r_new_high <= w_beats_high;
            end
        end
    end

    // Difficulty steps up on every hundreds carry, saturating at the top step.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_speed <= 2'd0;
        end else if (w_restart) begin
            r_speed <= 2'd0;
        end else if (w_hcarry && (r_speed < c_SPEED_MAX)) begin
            r_speed <= r_speed + 2'd1;
        end
    end

    // Registered display outputs built from next-cycle values so they track
    // the internal state with a single cycle of latency.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_alive <= 1'b1;
            r_disp  <= 16'h0000;
        end else begin
            r_alive <= (w_state_next != DEAD);
            r_disp  <= ((w_state_next == DEAD) && show_high) ? w_high_next : w_score_next;
        end
    end

    assign alive       = r_alive;
    assign score3      = r_disp[15:12];
    assign score2      = r_disp[11:8];
    assign score1      = r_disp[7:4];
    assign score0      = r_disp[3:0];
    assign new_high    = r_new_high;
    assign speed_level = r_speed;

endmodule : score_controller
`default_nettype wire
